// File: rtl/bus_pkg.sv
// Shared bus definitions for the burst RAM slave: FSM state encoding,
// bus field widths and the RAM word access flags.
package bus_pkg;

    localparam int dataWidth       = 32;
    localparam int byteEnableWidth = 4;
    localparam int burstSizeWidth  = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_BURST,
        READ_END,
        WRITE,
        WRITE_ERROR,
        READ_ERROR
    } busState_t;

    typedef struct packed {
        logic readWord;
        logic writeWord;
    } wordAccess_t;

endpackage

// File: rtl/ram_word_store.sv
// Single-port synchronous word RAM with per-byte write lanes.
// The read register returns 0 on cycles without a read, so it can drive
// the bus data output directly.
module ram_word_store
    import bus_pkg::*;
#(
    parameter int addressBits = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [addressBits-1:0]     address,
    input  wordAccess_t                access,
    input  logic [byteEnableWidth-1:0] byteEnables,
    input  logic [dataWidth-1:0]       writeData,
    output logic [dataWidth-1:0]       readData
);

    logic [dataWidth-1:0] mem [0:(1 << addressBits) - 1];

    // Byte-lane writes; contents survive reset.
    always_ff @(posedge clock) begin
        for (int lane = 0; lane < byteEnableWidth; lane++) begin
            if (access.writeWord && byteEnables[lane]) begin
                mem[address][8*lane +: 8] <= writeData[8*lane +: 8];
            end
        end
    end

    // Registered read port, zero whenever no word is being read.
    always_ff @(posedge clock) begin
        if (reset) begin
            readData <= '0;
        end else if (access.readWord) begin
            readData <= mem[address];
        end else begin
            readData <= '0;
        end
    end

endmodule

// File: rtl/burst_ram_slave.sv
// Burst RAM slave answering DMA master begin/data/end handshakes.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a begin inside the address window
// READ_WAIT   | counting read latency before the first beat is issued
// READ_BURST  | one RAM word read per cycle, shown on the bus a cycle later
// READ_END    | last beat on the bus; endTransactionOut follows
// WRITE       | accepting write beats, inserting busy stalls
// WRITE_ERROR | out-of-range write; discard data until endTransactionIn
// READ_ERROR  | out-of-range read; busErrorOut shown, endTransactionOut next
module burst_ram_slave
    import bus_pkg::*;
#(
    parameter logic [31:0] baseAddress = 32'h40000000,
    parameter int          addressBits = 10,
    parameter int          readLatency = 2,
    parameter int          busyEvery   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       beginTransactionIn,
    input  logic                       readNotWriteIn,
    input  logic [byteEnableWidth-1:0] byteEnablesIn,
    input  logic [burstSizeWidth-1:0]  burstSizeIn,
    input  logic [dataWidth-1:0]       addressDataIn,
    input  logic                       dataValidIn,
    input  logic                       endTransactionIn,
    output logic [dataWidth-1:0]       addressDataOut,
    output logic                       dataValidOut,
    output logic                       endTransactionOut,
    output logic                       busyOut,
    output logic                       busErrorOut
);

    localparam int          wordCount = 1 << addressBits;
    localparam logic [3:0]  waitLoad  = (readLatency == 0) ? 4'd0 : 4'(readLatency - 1);
    localparam logic [15:0] busyLoad  = (busyEvery == 0) ? 16'd0 : 16'(busyEvery - 1);

    busState_t                  state, nextState;
    logic [addressBits-1:0]     pointer;
    logic [burstSizeWidth:0]    beatsLeft;
    logic [3:0]                 waitCount;
    logic [15:0]                stallCount;
    logic [byteEnableWidth-1:0] byteEnables;
    wordAccess_t                access;
    logic [31:0]                lastWord;
    logic                       selected, rangeError, beatAccepted;
    logic                       dataValidNext, endNext, busyNext, errorNext;

    assign selected     = beginTransactionIn &&
                          (addressDataIn[31:addressBits+2] == baseAddress[31:addressBits+2]);
    assign lastWord     = 32'(addressDataIn[addressBits+1:2]) + 32'(burstSizeIn);
    assign rangeError   = lastWord > 32'(wordCount - 1);
    assign beatAccepted = (state == WRITE) && dataValidIn && !busyOut;

    // State register and registered bus outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busyOut           <= 1'b0;
            busErrorOut       <= 1'b0;
        end else begin
            state             <= nextState;
            dataValidOut      <= dataValidNext;
            endTransactionOut <= endNext;
            busyOut           <= busyNext;
            busErrorOut       <= errorNext;
        end
    end

    // Burst datapath: word pointer, remaining-beat, latency and stall down-counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            pointer     <= '0;
            beatsLeft   <= '0;
            waitCount   <= '0;
            stallCount  <= '0;
            byteEnables <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (selected) begin
                        pointer     <= addressDataIn[addressBits+1:2];
                        beatsLeft   <= {1'b0, burstSizeIn} + 9'd1;
                        waitCount   <= waitLoad;
                        stallCount  <= busyLoad;
                        byteEnables <= byteEnablesIn;
                    end
                end
                READ_WAIT: begin
                    if (waitCount != 4'd0) begin
                        waitCount <= waitCount - 4'd1;
                    end
                end
                READ_BURST: begin
                    pointer   <= pointer + addressBits'(1);
                    beatsLeft <= beatsLeft - 9'd1;
                end
                WRITE: begin
                    if (beatAccepted) begin
                        if (beatsLeft != 9'd0) begin
                            pointer   <= pointer + addressBits'(1);
                            beatsLeft <= beatsLeft - 9'd1;
                        end
                        stallCount <= (stallCount == 16'd0) ? busyLoad : stallCount - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decision.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (selected) begin
                    if (rangeError) begin
                        nextState = readNotWriteIn ? READ_ERROR : WRITE_ERROR;
                    end else if (readNotWriteIn) begin
                        nextState = (readLatency == 0) ? READ_BURST : READ_WAIT;
                    end else begin
                        nextState = WRITE;
                    end
                end
            end
            READ_WAIT:   if (waitCount == 4'd0) nextState = READ_BURST;
            READ_BURST:  if (beatsLeft == 9'd1) nextState = READ_END;
            READ_END:    nextState = IDLE;
            READ_ERROR:  nextState = IDLE;
            WRITE:       if (endTransactionIn) nextState = IDLE;
            WRITE_ERROR: if (endTransactionIn) nextState = IDLE;
            default:     nextState = IDLE;
        endcase
    end

    // Output decode: values the output registers take on the next edge, plus RAM access.
    always_comb begin
        dataValidNext = 1'b0;
        endNext       = 1'b0;
        busyNext      = 1'b0;
        errorNext     = 1'b0;
        access        = '0;
        case (state)
            IDLE:        errorNext = selected && rangeError;
            READ_BURST: begin
                dataValidNext   = 1'b1;
                access.readWord = 1'b1;
            end
            READ_END:    endNext = 1'b1;
            READ_ERROR:  endNext = 1'b1;
            WRITE: begin
                access.writeWord = beatAccepted && (beatsLeft != 9'd0);
                busyNext = (busyEvery != 0) && beatAccepted &&
                           (stallCount == 16'd0) && !endTransactionIn;
            end
            default: ;
        endcase
    end

    ram_word_store #(
        .addressBits (addressBits)
    ) wordStore (
        .clock       (clock),
        .reset       (reset),
        .address     (pointer),
        .access      (access),
        .byteEnables (byteEnables),
        .writeData   (addressDataIn),
        .readData    (addressDataOut)
    );

endmodule
